// File: rtl/ffstdp_update_pipe_if.sv
// Handshake and data bundle between the synaptic SRAM read side, the
// FF-STDP update pipe and the write-back consumer.
interface ffstdp_update_pipe_if #(
  parameter int LANES          = 4,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int PRE_CNT_WIDTH  = 8,
  parameter int POST_CNT_WIDTH = 7,
  parameter int LR_WIDTH       = 3
);
  logic                             in_valid;
  logic                             in_ready;
  logic                             ctrl_tref_event;
  logic                             is_train;
  logic                             is_pos;
  logic [LR_WIDTH-1:0]              lr_shift;
  logic [PRE_CNT_WIDTH-1:0]         pre_spike_cnt;
  logic [LANES*POST_CNT_WIDTH-1:0]  post_spike_cnt;
  logic [LANES*WEIGHT_WIDTH-1:0]    wsyn_curr;
  logic                             out_valid;
  logic                             out_ready;
  logic [LANES*WEIGHT_WIDTH-1:0]    wsyn_new;

  modport master (
    output in_valid, ctrl_tref_event, is_train, is_pos, lr_shift,
           pre_spike_cnt, post_spike_cnt, wsyn_curr, out_ready,
    input  in_ready, out_valid, wsyn_new
  );

  modport slave (
    input  in_valid, ctrl_tref_event, is_train, is_pos, lr_shift,
           pre_spike_cnt, post_spike_cnt, wsyn_curr, out_ready,
    output in_ready, out_valid, wsyn_new
  );
endinterface

// File: rtl/ffstdp_update_pipe.sv
// Multi-lane FF-STDP weight update pipe: S1 (weights, sideband, ROM read), S2 output register.
// Optional saturation counter port sat_cnt_o enabled by macro FFSTDP_SAT_CNT_EN.
module ffstdp_update_pipe #(
  parameter int LANES          = 4,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int DERIV_WIDTH    = 8,
  parameter int PRE_CNT_WIDTH  = 8,
  parameter int POST_CNT_WIDTH = 7,
  parameter int LR_WIDTH       = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  ffstdp_update_pipe_if.slave io
`ifdef FFSTDP_SAT_CNT_EN
  ,
  output logic [15:0]         sat_cnt_o
`endif
);
  localparam int WW = WEIGHT_WIDTH;
  localparam int PW = POST_CNT_WIDTH;
  localparam logic signed [WW:0] W_MAX = $signed({2'b00, {(WW-1){1'b1}}});
  localparam logic signed [WW:0] W_MIN = $signed({2'b11, {(WW-1){1'b0}}});

  // Counts saturate at 16 so large counts map to the last ROM row/column.
  function automatic logic [3:0] enc_pre(input logic [PRE_CNT_WIDTH-1:0] c);
    if (c >= PRE_CNT_WIDTH'(16)) return 4'hF;
    return c[3:0] - 4'd1;
  endfunction

  function automatic logic [3:0] enc_post(input logic [PW-1:0] c);
    if (c >= PW'(16)) return 4'hF;
    return c[3:0] - 4'd1;
  endfunction

  function automatic logic signed [DERIV_WIDTH-1:0] rom_pos(input logic [7:0] a);
    return DERIV_WIDTH'(3 * int'(a[7:4]) + 2 * int'(a[3:0]));
  endfunction

  function automatic logic signed [DERIV_WIDTH-1:0] rom_neg(input logic [7:0] a);
    return DERIV_WIDTH'(-(int'(a[7:4]) + 2 * int'(a[3:0])));
  endfunction

  logic                          stall;
  logic                          accept;
  logic                          s1_valid_q;
  logic                          s1_upd_q;
  logic                          s1_pos_q;
  logic                          s1_pre_zero_q;
  logic [LR_WIDTH-1:0]           s1_lr_q;
  logic [LANES-1:0]              s1_post_zero_q;
  logic [LANES*WW-1:0]           s1_w_q;
  logic [7:0]                    s1_addr_q [LANES];
  logic [7:0]                    addr_d    [LANES];
  logic [7:0]                    rom_addr  [LANES];
  logic [LANES-1:0]              post_zero_d;
  logic signed [DERIV_WIDTH-1:0] pos_dout_q [LANES];
  logic signed [DERIV_WIDTH-1:0] neg_dout_q [LANES];
  logic signed [WW:0]            sum [LANES];
  logic [LANES*WW-1:0]           wsyn_d;
  logic                          s2_valid_q;
  logic [LANES*WW-1:0]           s2_w_q;

  assign stall        = s2_valid_q & ~io.out_ready;
  assign accept       = io.in_valid & ~stall;
  assign io.in_ready  = ~stall;
  assign io.out_valid = s2_valid_q;
  assign io.wsyn_new  = s2_w_q;

  // While stalled the ROM re-reads the S1 address so its output stays paired with S1.
  always_comb begin
    post_zero_d = '0;
    for (int i = 0; i < LANES; i++) begin
      addr_d[i]      = {enc_pre(io.pre_spike_cnt), enc_post(io.post_spike_cnt[i*PW +: PW])};
      post_zero_d[i] = (io.post_spike_cnt[i*PW +: PW] == '0);
      rom_addr[i]    = stall ? s1_addr_q[i] : addr_d[i];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < LANES; i++) begin
      pos_dout_q[i] <= rom_pos(rom_addr[i]);
      neg_dout_q[i] <= rom_neg(rom_addr[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid_q     <= 1'b0;
      s1_upd_q       <= 1'b0;
      s1_pos_q       <= 1'b0;
      s1_pre_zero_q  <= 1'b0;
      s1_lr_q        <= '0;
      s1_post_zero_q <= '0;
      s1_w_q         <= '0;
      for (int i = 0; i < LANES; i++) s1_addr_q[i] <= '0;
    end else if (!stall) begin
      s1_valid_q     <= accept;
      s1_upd_q       <= io.ctrl_tref_event & io.is_train;
      s1_pos_q       <= io.is_pos;
      s1_pre_zero_q  <= (io.pre_spike_cnt == '0);
      s1_lr_q        <= io.lr_shift;
      s1_post_zero_q <= post_zero_d;
      s1_w_q         <= io.wsyn_curr;
      for (int i = 0; i < LANES; i++) s1_addr_q[i] <= addr_d[i];
    end
  end

  always_comb begin
    logic signed [DERIV_WIDTH-1:0] deriv;
    logic signed [WW:0]            deriv_x;
    logic signed [WW:0]            delta;
    logic signed [WW:0]            w_x;
    deriv   = '0;
    deriv_x = '0;
    delta   = '0;
    w_x     = '0;
    wsyn_d  = s1_w_q;
    for (int i = 0; i < LANES; i++) begin
      deriv = s1_pos_q ? pos_dout_q[i] : neg_dout_q[i];
      if (s1_pre_zero_q || s1_post_zero_q[i]) begin
        delta = '0;
      end else begin
        deriv_x = {{(WW+1-DERIV_WIDTH){deriv[DERIV_WIDTH-1]}}, deriv};
        delta   = deriv_x >>> s1_lr_q;
      end
      w_x    = {s1_w_q[i*WW+WW-1], s1_w_q[i*WW +: WW]};
      sum[i] = w_x + delta;
      if (s1_upd_q) begin
        if (sum[i] > W_MAX)      wsyn_d[i*WW +: WW] = W_MAX[WW-1:0];
        else if (sum[i] < W_MIN) wsyn_d[i*WW +: WW] = W_MIN[WW-1:0];
        else                     wsyn_d[i*WW +: WW] = sum[i][WW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s2_valid_q <= 1'b0;
      s2_w_q     <= '0;
    end else if (!stall) begin
      s2_valid_q <= s1_valid_q;
      s2_w_q     <= wsyn_d;
    end
  end

`ifdef FFSTDP_SAT_CNT_EN
  logic [15:0] sat_cnt_q;
  logic [7:0]  hits;
  logic [16:0] sat_sum;

  always_comb begin
    hits = '0;
    for (int i = 0; i < LANES; i++) begin
      if (sum[i] > W_MAX || sum[i] < W_MIN) hits = hits + 8'd1;
    end
    sat_sum = {1'b0, sat_cnt_q} + 17'(hits);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sat_cnt_q <= '0;
    end else if (s1_valid_q && s1_upd_q && !stall) begin
      sat_cnt_q <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
    end
  end

  assign sat_cnt_o = sat_cnt_q;
`endif
endmodule

// File: tb/tb_ffstdp_update_pipe.sv
// Scoreboard bench for ffstdp_update_pipe: directed words, saturation, pass-through,
// random backpressure and mid-stream reset.
module tb_ffstdp_update_pipe;
  localparam int LANES = 4;
  localparam int WW    = 8;
  localparam int PW    = 8;
  localparam int QW    = 7;
  localparam int LW    = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ffstdp_update_pipe_if #(
    .LANES(LANES), .WEIGHT_WIDTH(WW), .PRE_CNT_WIDTH(PW),
    .POST_CNT_WIDTH(QW), .LR_WIDTH(LW)
  ) bus ();

`ifdef FFSTDP_SAT_CNT_EN
  logic [15:0] sat_cnt;
`endif

  ffstdp_update_pipe dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .io        (bus)
`ifdef FFSTDP_SAT_CNT_EN
    ,
    .sat_cnt_o (sat_cnt)
`endif
  );

  int checks   = 0;
  int failures = 0;
  logic [LANES*WW-1:0] exp_q [$];
  logic [LANES*WW-1:0] cur_exp;
  logic accepted;
  logic rand_ready;
  int pre_v, pos_v, lr_v, train_v, tref_v;
  int post_v [LANES];
  int w_v    [LANES];

  // Derivative table: pos = 3*enc(pre) + 2*enc(post), neg = -(enc(pre) + 2*enc(post)).
  function automatic int model_lane(int pre, int post, int w, int pos, int lr, int upd);
    int p, q, deriv, d, s;
    if (upd == 0) return w;
    d = 0;
    if (pre != 0 && post != 0) begin
      p = (pre >= 16) ? 15 : pre - 1;
      q = (post >= 16) ? 15 : post - 1;
      deriv = pos ? (3 * p + 2 * q) : -(p + 2 * q);
      d = deriv >>> lr;
    end
    s = w + d;
    if (s > 127)  s = 127;
    if (s < -128) s = -128;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    int upd;
    upd = (train_v != 0 && tref_v != 0) ? 1 : 0;
    bus.pre_spike_cnt   = PW'(pre_v);
    bus.is_pos          = pos_v[0];
    bus.lr_shift        = LW'(lr_v);
    bus.is_train        = train_v[0];
    bus.ctrl_tref_event = tref_v[0];
    for (int i = 0; i < LANES; i++) begin
      bus.post_spike_cnt[i*QW +: QW] = QW'(post_v[i]);
      bus.wsyn_curr[i*WW +: WW]      = WW'(w_v[i]);
      cur_exp[i*WW +: WW] = WW'(model_lane(pre_v, post_v[i], w_v[i], pos_v, lr_v, upd));
    end
    bus.in_valid = 1'b1;
  endtask

  task automatic tick();
    if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    accepted = 1'b0;
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 32'(bus.out_valid), 32'd0);
        else                   chk("word", bus.wsyn_new, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(cur_exp);
        accepted = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send();
    drive();
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) tick();
    chk("accept_timeout", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && exp_q.size() != 0; n++) tick();
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic set_lanes(input int p0, p1, p2, p3, input int w0, w1, w2, w3);
    post_v[0] = p0; post_v[1] = p1; post_v[2] = p2; post_v[3] = p3;
    w_v[0] = w0; w_v[1] = w1; w_v[2] = w2; w_v[3] = w3;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rand_ready = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.ctrl_tref_event = 1'b0;
    bus.is_train = 1'b0;
    bus.is_pos = 1'b0;
    bus.lr_shift = '0;
    bus.pre_spike_cnt = '0;
    bus.post_spike_cnt = '0;
    bus.wsyn_curr = '0;
    cur_exp = '0;
    accepted = 1'b0;
    repeat (3) tick();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_wsyn_new", bus.wsyn_new, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Basic update with explicit latency check
    pre_v = 3; pos_v = 1; lr_v = 0; train_v = 1; tref_v = 1;
    set_lanes(2, 2, 1, 4, 16, -10, 5, 0);
    drive();
    tick();
    chk("basic_accept", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
    chk("lat_edge1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("lat_edge2_valid", 32'(bus.out_valid), 32'd1);
    chk("basic_lane0", 32'(bus.wsyn_new[7:0]), 32'd24);
    drain();

    // Saturation high then low
    pre_v = 5; pos_v = 1;
    set_lanes(3, 3, 3, 3, 120, 0, 0, 0);
    send();
    pre_v = 3; pos_v = 0;
    set_lanes(8, 8, 8, 8, 0, -120, 0, 0);
    send();
    drain();
`ifdef FFSTDP_SAT_CNT_EN
    chk("sat_cnt", 32'(sat_cnt), 32'd2);
`endif

    // PRE == 0 leaves weights alone
    pre_v = 0; pos_v = 1;
    set_lanes(5, 9, 1, 50, 33, -7, 100, -100);
    send();
    // Large counts clamp to the last ROM entry
    pre_v = 40;
    set_lanes(100, 16, 17, 1, 0, 0, 0, 0);
    send();
    // Negative pass with shift: -5 >>> 1 = -3
    pre_v = 2; pos_v = 0; lr_v = 1;
    set_lanes(3, 1, 1, 1, 10, 10, -10, 0);
    send();
    // Pass-through without training, then without tref
    pre_v = 4; pos_v = 1; lr_v = 0; train_v = 0; tref_v = 1;
    set_lanes(4, 4, 4, 4, 1, 2, 3, 4);
    send();
    train_v = 1; tref_v = 0;
    set_lanes(4, 4, 4, 4, 11, 12, 13, 14);
    send();
    drain();

    // Random backpressure, back-to-back words
    rand_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      pre_v = $urandom_range(0, 40); pos_v = $urandom_range(0, 1);
      lr_v = $urandom_range(0, 7); train_v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      tref_v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      for (int i = 0; i < LANES; i++) begin
        post_v[i] = $urandom_range(0, 100);
        w_v[i] = int'($urandom_range(0, 255)) - 128;
      end
      send();
    end
    drain();

    // Words in flight, then reset
    for (int k = 0; k < 4; k++) begin
      pre_v = $urandom_range(1, 30); pos_v = k % 2; lr_v = k; train_v = 1; tref_v = 1;
      for (int i = 0; i < LANES; i++) begin
        post_v[i] = $urandom_range(1, 30);
        w_v[i] = int'($urandom_range(0, 255)) - 128;
      end
      send();
    end
    rst_n = 1'b0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    rand_ready = 1'b0;
    bus.out_ready = 1'b1;
`ifdef FFSTDP_SAT_CNT_EN
    chk("sat_cnt_rst", 32'(sat_cnt), 32'd0);
`endif
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'd0);
    end
    pre_v = 3; pos_v = 1; lr_v = 0; train_v = 1; tref_v = 1;
    set_lanes(2, 2, 2, 2, 16, 16, 16, 16);
    send();
    drain();

    chk("final_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
